multi_zone_light_ctrl: RTL

Parametrised automatic-lighting controller for N independent zones. Each zone turns its light on from a motion sensor, holds it on for a programmable number of time ticks after motion stops, optionally blinks a warning before switching off, and honours manual force-on/force-off controls. One free-running prescaler generates a tick shared by all zones. Sits between raw motion-sensor inputs and the lamp drivers.

---
 rtl/light_ctrl_pkg.sv | 11 +
 rtl/light_zone_fsm.sv | 116 +++++++++++
 rtl/multi_zone_light_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/light_ctrl_pkg.sv
// Shared types and helpers for the multi-zone lighting controller.
// Optional warning blink is enabled by defining LIGHT_CTRL_WARN_EN.
package light_ctrl_pkg;

    typedef enum logic [2:0] {OFF, ON, HOLD, WARN, MANUAL, LOCK} zone_state_e;

    function automatic int cnt_w(input int timeout_ticks);
        return $clog2(timeout_ticks + 1);
    endfunction

endpackage

// File: rtl/light_zone_fsm.sv
// One lighting zone: state, hold countdown, warning blink (LIGHT_CTRL_WARN_EN), lamp decode.
// Outputs follow the state register with no extra stage; no backpressure.
module light_zone_fsm
    import light_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 300
`ifdef LIGHT_CTRL_WARN_EN
    , parameter int WARN_TICKS = 30
`endif
) (
    input  logic clk,
    input  logic rstn,
    input  logic msync,
    input  logic force_on,
    input  logic force_off,
    input  logic tick,
    output logic light_on,
    output logic timeout_evt
);

    localparam int CW = cnt_w(TIMEOUT_TICKS);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_TICKS);

    zone_state_e   state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_dec;
`ifdef LIGHT_CTRL_WARN_EN
    logic          blink;
`endif

    assign cnt_dec = cnt - CW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= OFF;
            cnt         <= '0;
            timeout_evt <= 1'b0;
`ifdef LIGHT_CTRL_WARN_EN
            blink       <= 1'b0;
`endif
        end else begin
            timeout_evt <= 1'b0;
            if (force_off) begin
                state <= LOCK;
            end else if (force_on && state != MANUAL) begin
                state <= MANUAL;
            end else begin
                case (state)
                    OFF:  if (msync) state <= ON;
                    ON: begin
                        if (!msync) begin
                            state <= HOLD;
                            cnt   <= LOAD;
                        end
                    end
                    HOLD: begin
                        if (msync) begin
                            state <= ON;
                        end else if (tick) begin
                            cnt <= cnt_dec;
                            if (cnt_dec == '0) begin
                                state       <= OFF;
                                timeout_evt <= 1'b1;
                            end
`ifdef LIGHT_CTRL_WARN_EN
                            else if (cnt_dec == CW'(WARN_TICKS)) begin
                                state <= WARN;
                                blink <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef LIGHT_CTRL_WARN_EN
                    WARN: begin
                        if (msync) begin
                            state <= ON;
                        end else if (tick) begin
                            cnt   <= cnt_dec;
                            blink <= ~blink;
                            if (cnt_dec == '0) begin
                                state       <= OFF;
                                timeout_evt <= 1'b1;
                            end
                        end
                    end
`endif
                    // Count is frozen while forced on; release always starts a fresh hold.
                    MANUAL: begin
                        if (!force_on) begin
                            if (msync) begin
                                state <= ON;
                            end else begin
                                state <= HOLD;
                                cnt   <= LOAD;
                            end
                        end
                    end
                    LOCK:    if (!msync) state <= OFF;
                    default: state <= OFF;
                endcase
            end
        end
    end

    always_comb begin
        light_on = 1'b0;
        case (state)
            ON, HOLD, MANUAL: light_on = 1'b1;
`ifdef LIGHT_CTRL_WARN_EN
            WARN:             light_on = blink;
`endif
            default:          light_on = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_zone_light_ctrl.sv
// N-zone lighting controller: motion synchronisers, shared tick prescaler, per-zone FSMs (LIGHT_CTRL_WARN_EN adds blink warning).
// Motion to lamp: 3 clk edges; force controls: 1 edge; no backpressure.
module multi_zone_light_ctrl
    import light_ctrl_pkg::*;
#(
    parameter int N_ZONES       = 4,
    parameter int TICK_CYCLES   = 10_000_000,
    parameter int TIMEOUT_TICKS = 300,
    parameter int WARN_TICKS    = 30
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_ZONES-1:0] motion_detect,
    input  logic [N_ZONES-1:0] force_on,
    input  logic [N_ZONES-1:0] force_off,
    output logic [N_ZONES-1:0] light_on,
    output logic [N_ZONES-1:0] timeout_evt,
    output logic               any_on
);

    localparam int PW = $clog2(TICK_CYCLES);

    if (TIMEOUT_TICKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_TICKS must be at least 2");
    end
    if (TICK_CYCLES < 2) begin : g_bad_tick
        $error("TICK_CYCLES must be at least 2");
    end
    if (WARN_TICKS >= TIMEOUT_TICKS) begin : g_bad_warn
        $error("WARN_TICKS must be below TIMEOUT_TICKS");
    end

    logic [N_ZONES-1:0] msync_meta;
    logic [N_ZONES-1:0] msync;
    logic [PW-1:0]      pcnt;
    logic               tick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            msync_meta <= '0;
            msync      <= '0;
        end else begin
            msync_meta <= motion_detect;
            msync      <= msync_meta;
        end
    end

    assign tick = (pcnt == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        light_zone_fsm #(
            .TIMEOUT_TICKS(TIMEOUT_TICKS)
`ifdef LIGHT_CTRL_WARN_EN
            , .WARN_TICKS(WARN_TICKS)
`endif
        ) u_zone (
            .clk         (clk),
            .rstn        (rstn),
            .msync       (msync[z]),
            .force_on    (force_on[z]),
            .force_off   (force_off[z]),
            .tick        (tick),
            .light_on    (light_on[z]),
            .timeout_evt (timeout_evt[z])
        );
    end

    assign any_on = |light_on;

endmodule
